// File: rtl/lsu_mem_master.sv
// lsu_mem_master: load/store unit memory initiator.
//
// Accepts one load or store per request handshake, drives the memory bridge
// read or write strobe with 8-byte aligned addresses, waits for mem_ack, and
// returns lane-aligned, size-truncated, extended load data (or a store
// completion) on the response port. One access in flight at a time.
//
// Ports
//   clk, rst                  clock, asynchronous active-high reset
//   req_*                     request from execute (valid/ready)
//   resp_*                    response to writeback (valid/ready)
//   mem_raddr/mem_read        registered read strobe and aligned address
//   mem_waddr/mem_wdata/
//   mem_wmask/mem_write       registered write strobe, lane data and byte mask
//   mem_rdata, mem_ack        memory return data and completion
//   dbg_state                 current FSM state (IDLE=0 READ=1 WRITE=2 RESP=3)
//
// Optional feature: define LSU_TIMEOUT_EN to fault an access that sees no
// mem_ack within TIMEOUT_CYCLES cycles of strobe assertion.
//
// Handshakes: a transfer happens on a rising edge where valid and ready are
// both high; valid and payload stay stable until that edge.
module lsu_mem_master #(
  parameter int unsigned TIMEOUT_CYCLES = 256
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_wen,
  input  logic [63:0] req_addr,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  input  logic [63:0] req_wdata,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [63:0] resp_rdata,
  output logic        resp_fault,
  output logic [63:0] mem_raddr,
  output logic        mem_read,
  output logic [63:0] mem_waddr,
  output logic [63:0] mem_wdata,
  output logic [7:0]  mem_wmask,
  output logic        mem_write,
  input  logic [63:0] mem_rdata,
  input  logic        mem_ack,
  output logic [1:0]  dbg_state
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_READ  = 2'd1;
  localparam logic [1:0] S_WRITE = 2'd2;
  localparam logic [1:0] S_RESP  = 2'd3;

  logic [1:0]  state_q, state_d;
  logic [2:0]  off_q, off_d;
  logic [1:0]  size_q, size_d;
  logic        uns_q, uns_d;
  logic [63:0] resp_rdata_q, resp_rdata_d;
  logic        resp_fault_q, resp_fault_d;
  logic [63:0] mem_raddr_q, mem_raddr_d;
  logic        mem_read_q, mem_read_d;
  logic [63:0] mem_waddr_q, mem_waddr_d;
  logic [63:0] mem_wdata_q, mem_wdata_d;
  logic [7:0]  mem_wmask_q, mem_wmask_d;
  logic        mem_write_q, mem_write_d;
  logic        misaligned;
  logic        timed_out;
  logic [7:0]  size_mask;

  // Pick the addressed lane out of the full doubleword, truncate, extend.
  function automatic logic [63:0] load_ext(input logic [63:0] raw, input logic [2:0] off,
                                           input logic [1:0] sz, input logic uns);
    logic [63:0] s;
    s = raw >> {off, 3'b000};
    case (sz)
      2'd0:    load_ext = uns ? {56'd0, s[7:0]}  : {{56{s[7]}},  s[7:0]};
      2'd1:    load_ext = uns ? {48'd0, s[15:0]} : {{48{s[15]}}, s[15:0]};
      2'd2:    load_ext = uns ? {32'd0, s[31:0]} : {{32{s[31]}}, s[31:0]};
      default: load_ext = s;
    endcase
  endfunction

  always_comb begin
    case (req_size)
      2'd0:    misaligned = 1'b0;
      2'd1:    misaligned = req_addr[0];
      2'd2:    misaligned = |req_addr[1:0];
      default: misaligned = |req_addr[2:0];
    endcase
    case (req_size)
      2'd0:    size_mask = 8'h01;
      2'd1:    size_mask = 8'h03;
      2'd2:    size_mask = 8'h0F;
      default: size_mask = 8'hFF;
    endcase
  end

`ifdef LSU_TIMEOUT_EN
  // Counts strobe cycles; it is zero in IDLE/RESP so every access starts at 0.
  logic [31:0] timer_q, timer_d;
  assign timer_d   = ((state_q == S_READ) || (state_q == S_WRITE)) ? timer_q + 32'd1 : 32'd0;
  assign timed_out = (timer_q == TIMEOUT_CYCLES - 1);
  always_ff @(posedge clk or posedge rst) begin
    if (rst) timer_q <= 32'd0;
    else     timer_q <= timer_d;
  end
`else
  assign timed_out = 1'b0;
`endif

  always_comb begin
    state_d      = state_q;
    off_d        = off_q;
    size_d       = size_q;
    uns_d        = uns_q;
    resp_rdata_d = resp_rdata_q;
    resp_fault_d = resp_fault_q;
    mem_raddr_d  = mem_raddr_q;
    mem_read_d   = mem_read_q;
    mem_waddr_d  = mem_waddr_q;
    mem_wdata_d  = mem_wdata_q;
    mem_wmask_d  = mem_wmask_q;
    mem_write_d  = mem_write_q;
    case (state_q)
      S_IDLE: begin
        if (req_valid) begin
          off_d  = req_addr[2:0];
          size_d = req_size;
          uns_d  = req_unsigned;
          if (misaligned) begin
            state_d      = S_RESP;
            resp_fault_d = 1'b1;
            resp_rdata_d = 64'd0;
          end else if (req_wen) begin
            state_d     = S_WRITE;
            mem_write_d = 1'b1;
            mem_waddr_d = {req_addr[63:3], 3'b000};
            mem_wdata_d = req_wdata << {req_addr[2:0], 3'b000};
            mem_wmask_d = size_mask << req_addr[2:0];
          end else begin
            state_d     = S_READ;
            mem_read_d  = 1'b1;
            mem_raddr_d = {req_addr[63:3], 3'b000};
          end
        end
      end
      S_READ: begin
        if (mem_ack || timed_out) begin
          state_d      = S_RESP;
          mem_read_d   = 1'b0;
          mem_raddr_d  = 64'd0;
          resp_fault_d = !mem_ack;
          resp_rdata_d = mem_ack ? load_ext(mem_rdata, off_q, size_q, uns_q) : 64'd0;
        end
      end
      S_WRITE: begin
        if (mem_ack || timed_out) begin
          state_d      = S_RESP;
          mem_write_d  = 1'b0;
          mem_waddr_d  = 64'd0;
          mem_wdata_d  = 64'd0;
          mem_wmask_d  = 8'd0;
          resp_fault_d = !mem_ack;
          resp_rdata_d = 64'd0;
        end
      end
      default: begin
        if (resp_ready) begin
          state_d      = S_IDLE;
          resp_rdata_d = 64'd0;
          resp_fault_d = 1'b0;
        end
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= S_IDLE;
      off_q        <= 3'd0;
      size_q       <= 2'd0;
      uns_q        <= 1'b0;
      resp_rdata_q <= 64'd0;
      resp_fault_q <= 1'b0;
      mem_raddr_q  <= 64'd0;
      mem_read_q   <= 1'b0;
      mem_waddr_q  <= 64'd0;
      mem_wdata_q  <= 64'd0;
      mem_wmask_q  <= 8'd0;
      mem_write_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      off_q        <= off_d;
      size_q       <= size_d;
      uns_q        <= uns_d;
      resp_rdata_q <= resp_rdata_d;
      resp_fault_q <= resp_fault_d;
      mem_raddr_q  <= mem_raddr_d;
      mem_read_q   <= mem_read_d;
      mem_waddr_q  <= mem_waddr_d;
      mem_wdata_q  <= mem_wdata_d;
      mem_wmask_q  <= mem_wmask_d;
      mem_write_q  <= mem_write_d;
    end
  end

  assign req_ready  = (state_q == S_IDLE);
  assign resp_valid = (state_q == S_RESP);
  assign resp_rdata = resp_rdata_q;
  assign resp_fault = resp_fault_q;
  assign mem_raddr  = mem_raddr_q;
  assign mem_read   = mem_read_q;
  assign mem_waddr  = mem_waddr_q;
  assign mem_wdata  = mem_wdata_q;
  assign mem_wmask  = mem_wmask_q;
  assign mem_write  = mem_write_q;
  assign dbg_state  = state_q;

endmodule

// File: tb/tb_lsu_mem_master.sv
// Directed testbench for lsu_mem_master. Inputs change and outputs are
// sampled on the falling clock edge, away from the active rising edge.
module tb_lsu_mem_master;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0, req_ready, req_wen = 1'b0, req_unsigned = 1'b0;
  logic [63:0] req_addr = 64'd0, req_wdata = 64'd0;
  logic [1:0]  req_size = 2'd0;
  logic        resp_valid, resp_ready = 1'b0, resp_fault;
  logic [63:0] resp_rdata, mem_raddr, mem_waddr, mem_wdata;
  logic        mem_read, mem_write, mem_ack = 1'b0;
  logic [7:0]  mem_wmask;
  logic [63:0] mem_rdata = 64'd0;
  logic [1:0]  dbg_state;

  int pass_cnt = 0;
  int total_cnt = 0;

  // Observations collected by the driver task.
  logic [63:0] obs_raddr, obs_waddr, obs_wdata, obs_rdata;
  logic [7:0]  obs_wmask;
  logic        obs_got, obs_fault, obs_both;
  int          obs_rd_cyc, obs_wr_cyc, obs_wait;

  lsu_mem_master #(.TIMEOUT_CYCLES(8)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_wen(req_wen),
    .req_addr(req_addr), .req_size(req_size), .req_unsigned(req_unsigned),
    .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_rdata(resp_rdata), .resp_fault(resp_fault),
    .mem_raddr(mem_raddr), .mem_read(mem_read),
    .mem_waddr(mem_waddr), .mem_wdata(mem_wdata), .mem_wmask(mem_wmask),
    .mem_write(mem_write), .mem_rdata(mem_rdata), .mem_ack(mem_ack),
    .dbg_state(dbg_state)
  );

  always #5 clk = ~clk;

  // Drive one request, ack after ack_delay strobe cycles (negative = never),
  // capture the response, then complete the response handshake.
  task automatic run_access(input logic wen, input logic [63:0] addr, input logic [1:0] size,
                            input logic uns, input logic [63:0] wdata,
                            input logic [63:0] rdata, input int ack_delay);
    int strobe_cyc;
    @(negedge clk);
    req_valid = 1'b1; req_wen = wen; req_addr = addr; req_size = size;
    req_unsigned = uns; req_wdata = wdata;
    @(negedge clk);
    req_valid = 1'b0;
    obs_raddr = 64'd0; obs_waddr = 64'd0; obs_wdata = 64'd0; obs_wmask = 8'd0;
    obs_rdata = 64'd0; obs_fault = 1'b0; obs_got = 1'b0; obs_both = 1'b0;
    obs_rd_cyc = 0; obs_wr_cyc = 0; obs_wait = 0; strobe_cyc = 0;
    while (!obs_got && obs_wait < 50) begin
      mem_ack = 1'b0;
      if (resp_valid) begin
        obs_got = 1'b1; obs_rdata = resp_rdata; obs_fault = resp_fault;
      end else begin
        if (mem_read && mem_write) obs_both = 1'b1;
        if (mem_read)  begin obs_rd_cyc++; obs_raddr = mem_raddr; end
        if (mem_write) begin obs_wr_cyc++; obs_waddr = mem_waddr; obs_wdata = mem_wdata; obs_wmask = mem_wmask; end
        if (mem_read || mem_write) begin
          if (strobe_cyc == ack_delay) begin mem_ack = 1'b1; mem_rdata = rdata; end
          strobe_cyc++;
        end
        @(negedge clk);
        obs_wait++;
      end
    end
    mem_ack = 1'b0;
    if (obs_got) begin
      resp_ready = 1'b1;
      @(negedge clk);
      resp_ready = 1'b0;
    end
  endtask

  task automatic test_reset;
    @(negedge clk);
    total_cnt++; if (req_ready !== 1'b1) $display("FAIL reset_req_ready got %b exp 1", req_ready); else pass_cnt++;
    total_cnt++; if (resp_valid !== 1'b0) $display("FAIL reset_resp_valid got %b exp 0", resp_valid); else pass_cnt++;
    total_cnt++; if ({mem_read, mem_write} !== 2'b00) $display("FAIL reset_strobes got %b exp 00", {mem_read, mem_write}); else pass_cnt++;
    total_cnt++; if ({mem_raddr, mem_waddr, mem_wdata, mem_wmask} !== 200'd0) $display("FAIL reset_mem_bus got nonzero exp 0"); else pass_cnt++;
    total_cnt++; if ({resp_rdata, resp_fault} !== 65'd0) $display("FAIL reset_resp got %h/%b exp 0/0", resp_rdata, resp_fault); else pass_cnt++;
    rst = 1'b0;
    @(negedge clk);
    total_cnt++; if (req_ready !== 1'b1) $display("FAIL post_reset_ready got %b exp 1", req_ready); else pass_cnt++;
  endtask

  task automatic test_loads;
    run_access(1'b0, 64'h80000003, 2'd0, 1'b0, 64'd0, 64'h1122334455667788, 1);
    total_cnt++; if (obs_raddr !== 64'h80000000) $display("FAIL lb_raddr got %h exp %h", obs_raddr, 64'h80000000); else pass_cnt++;
    total_cnt++; if (obs_rdata !== 64'h55) $display("FAIL lb_rdata got %h exp %h", obs_rdata, 64'h55); else pass_cnt++;
    total_cnt++; if (obs_rd_cyc !== 2 || obs_wr_cyc !== 0) $display("FAIL lb_strobe_cycles got rd=%0d wr=%0d exp rd=2 wr=0", obs_rd_cyc, obs_wr_cyc); else pass_cnt++;
    total_cnt++; if (obs_fault !== 1'b0) $display("FAIL lb_fault got %b exp 0", obs_fault); else pass_cnt++;
    run_access(1'b0, 64'h80000006, 2'd1, 1'b0, 64'd0, 64'h1122334455667788, 0);
    total_cnt++; if (obs_rdata !== 64'h1122) $display("FAIL lh_rdata got %h exp %h", obs_rdata, 64'h1122); else pass_cnt++;
    total_cnt++; if (obs_wait !== 1) $display("FAIL lh_latency got %0d exp 1", obs_wait); else pass_cnt++;
    run_access(1'b0, 64'h80000000, 2'd2, 1'b0, 64'd0, 64'h0000000080000001, 0);
    total_cnt++; if (obs_rdata !== 64'hFFFFFFFF80000001) $display("FAIL lw_sext got %h exp %h", obs_rdata, 64'hFFFFFFFF80000001); else pass_cnt++;
    run_access(1'b0, 64'h80000002, 2'd1, 1'b0, 64'd0, 64'h000000009ABC0000, 0);
    total_cnt++; if (obs_rdata !== 64'hFFFFFFFFFFFF9ABC) $display("FAIL lh_sext got %h exp %h", obs_rdata, 64'hFFFFFFFFFFFF9ABC); else pass_cnt++;
    run_access(1'b0, 64'h80000002, 2'd1, 1'b1, 64'd0, 64'h000000009ABC0000, 0);
    total_cnt++; if (obs_rdata !== 64'h9ABC) $display("FAIL lhu_zext got %h exp %h", obs_rdata, 64'h9ABC); else pass_cnt++;
    run_access(1'b0, 64'h80000007, 2'd0, 1'b1, 64'd0, 64'hF100000000000000, 0);
    total_cnt++; if (obs_rdata !== 64'hF1) $display("FAIL lbu_top_lane got %h exp %h", obs_rdata, 64'hF1); else pass_cnt++;
    run_access(1'b0, 64'h80000008, 2'd3, 1'b0, 64'd0, 64'h0123456789ABCDEF, 0);
    total_cnt++; if (obs_rdata !== 64'h0123456789ABCDEF || obs_raddr !== 64'h80000008) $display("FAIL ld got %h@%h exp %h@%h", obs_rdata, obs_raddr, 64'h0123456789ABCDEF, 64'h80000008); else pass_cnt++;
  endtask

  task automatic test_stores;
    run_access(1'b1, 64'h80000002, 2'd1, 1'b0, 64'hABCD, 64'd0, 0);
    total_cnt++; if (obs_wmask !== 8'b00001100) $display("FAIL sh_wmask got %b exp 00001100", obs_wmask); else pass_cnt++;
    total_cnt++; if (obs_wdata !== 64'h00000000ABCD0000) $display("FAIL sh_wdata got %h exp %h", obs_wdata, 64'h00000000ABCD0000); else pass_cnt++;
    total_cnt++; if (obs_waddr !== 64'h80000000) $display("FAIL sh_waddr got %h exp %h", obs_waddr, 64'h80000000); else pass_cnt++;
    total_cnt++; if (obs_wr_cyc !== 1 || obs_rd_cyc !== 0 || obs_both !== 1'b0) $display("FAIL sh_strobes got wr=%0d rd=%0d both=%b exp 1/0/0", obs_wr_cyc, obs_rd_cyc, obs_both); else pass_cnt++;
    total_cnt++; if (obs_fault !== 1'b0 || obs_rdata !== 64'd0) $display("FAIL sh_resp got %b/%h exp 0/0", obs_fault, obs_rdata); else pass_cnt++;
    run_access(1'b1, 64'h80000007, 2'd0, 1'b0, 64'h5A, 64'd0, 0);
    total_cnt++; if (obs_wmask !== 8'h80 || obs_wdata !== 64'h5A00000000000000) $display("FAIL sb_lane got %h/%h exp 80/%h", obs_wmask, obs_wdata, 64'h5A00000000000000); else pass_cnt++;
    run_access(1'b1, 64'h80000010, 2'd3, 1'b0, 64'hDEADBEEFCAFEF00D, 64'd0, 2);
    total_cnt++; if (obs_wmask !== 8'hFF || obs_wdata !== 64'hDEADBEEFCAFEF00D || obs_wr_cyc !== 3) $display("FAIL sd got %h/%h/%0d exp FF/%h/3", obs_wmask, obs_wdata, obs_wr_cyc, 64'hDEADBEEFCAFEF00D); else pass_cnt++;
    total_cnt++; if ({mem_write, mem_wmask, mem_wdata, mem_waddr} !== 137'd0) $display("FAIL idle_write_bus got nonzero exp 0"); else pass_cnt++;
  endtask

  task automatic test_misaligned;
    run_access(1'b0, 64'h80000002, 2'd2, 1'b0, 64'd0, 64'hFFFFFFFFFFFFFFFF, 0);
    total_cnt++; if (obs_rd_cyc !== 0) $display("FAIL mis_lw_no_read got %0d exp 0", obs_rd_cyc); else pass_cnt++;
    total_cnt++; if (obs_got !== 1'b1 || obs_fault !== 1'b1 || obs_rdata !== 64'd0) $display("FAIL mis_lw_resp got %b/%b/%h exp 1/1/0", obs_got, obs_fault, obs_rdata); else pass_cnt++;
    total_cnt++; if (obs_wait > 1) $display("FAIL mis_lw_latency got %0d exp <=1", obs_wait); else pass_cnt++;
    run_access(1'b1, 64'h80000001, 2'd1, 1'b0, 64'h1234, 64'd0, 0);
    total_cnt++; if (obs_wr_cyc !== 0 || obs_fault !== 1'b1) $display("FAIL mis_sh got wr=%0d fault=%b exp 0/1", obs_wr_cyc, obs_fault); else pass_cnt++;
    run_access(1'b0, 64'h80000004, 2'd3, 1'b0, 64'd0, 64'd0, 0);
    total_cnt++; if (obs_rd_cyc !== 0 || obs_fault !== 1'b1) $display("FAIL mis_ld got rd=%0d fault=%b exp 0/1", obs_rd_cyc, obs_fault); else pass_cnt++;
  endtask

  task automatic test_backpressure;
    int bad;
    @(negedge clk);
    req_valid = 1'b1; req_wen = 1'b0; req_addr = 64'h80000004; req_size = 2'd2; req_unsigned = 1'b1;
    @(negedge clk);
    req_addr = 64'h80000010;  // stays valid: must be ignored while busy
    mem_ack = 1'b1; mem_rdata = 64'hCAFEBABE00000000;
    @(negedge clk);
    mem_ack = 1'b0;
    total_cnt++; if (resp_valid !== 1'b1 || resp_rdata !== 64'hCAFEBABE) $display("FAIL bp_first_resp got %b/%h exp 1/%h", resp_valid, resp_rdata, 64'hCAFEBABE); else pass_cnt++;
    bad = 0;
    for (int i = 0; i < 5; i++) begin
      mem_ack = (i == 2);  // stray ack in RESP is ignored
      @(negedge clk);
      if (resp_valid !== 1'b1 || resp_rdata !== 64'hCAFEBABE || req_ready !== 1'b0 || mem_read !== 1'b0) bad++;
    end
    mem_ack = 1'b0;
    total_cnt++; if (bad !== 0) $display("FAIL bp_hold_stable got %0d bad cycles exp 0", bad); else pass_cnt++;
    resp_ready = 1'b1;
    @(negedge clk);
    resp_ready = 1'b0;
    total_cnt++; if (resp_valid !== 1'b0 || resp_rdata !== 64'd0 || req_ready !== 1'b1) $display("FAIL bp_release got %b/%h/%b exp 0/0/1", resp_valid, resp_rdata, req_ready); else pass_cnt++;
    // Still-asserted request is taken right after the handshake.
    @(negedge clk);
    req_valid = 1'b0;
    total_cnt++; if (mem_read !== 1'b1 || mem_raddr !== 64'h80000010) $display("FAIL b2b_accept got %b/%h exp 1/%h", mem_read, mem_raddr, 64'h80000010); else pass_cnt++;
    mem_ack = 1'b1; mem_rdata = 64'h77;
    @(negedge clk);
    mem_ack = 1'b0; resp_ready = 1'b1;
    @(negedge clk);
    resp_ready = 1'b0;
  endtask

  task automatic test_reset_mid_read;
    int bad;
    @(negedge clk);
    req_valid = 1'b1; req_wen = 1'b0; req_addr = 64'h80000000; req_size = 2'd3;
    @(negedge clk);
    req_valid = 1'b0;
    total_cnt++; if (mem_read !== 1'b1) $display("FAIL mid_read_strobe got %b exp 1", mem_read); else pass_cnt++;
    rst = 1'b1;
    #1;
    total_cnt++; if (mem_read !== 1'b0 || mem_raddr !== 64'd0) $display("FAIL async_reset_strobe got %b/%h exp 0/0", mem_read, mem_raddr); else pass_cnt++;
    @(negedge clk);
    rst = 1'b0;
    bad = 0;
    for (int i = 0; i < 5; i++) begin
      mem_ack = (i == 0);
      @(negedge clk);
      if (resp_valid !== 1'b0 || req_ready !== 1'b1 || mem_read !== 1'b0) bad++;
    end
    mem_ack = 1'b0;
    total_cnt++; if (bad !== 0) $display("FAIL reset_drops_access got %0d bad cycles exp 0", bad); else pass_cnt++;
  endtask

  task automatic test_timeout;
`ifdef LSU_TIMEOUT_EN
    run_access(1'b0, 64'h80000000, 2'd3, 1'b0, 64'd0, 64'd0, -1);
    total_cnt++; if (obs_rd_cyc !== 8) $display("FAIL timeout_read_cycles got %0d exp 8", obs_rd_cyc); else pass_cnt++;
    total_cnt++; if (obs_got !== 1'b1 || obs_fault !== 1'b1 || obs_rdata !== 64'd0) $display("FAIL timeout_resp got %b/%b/%h exp 1/1/0", obs_got, obs_fault, obs_rdata); else pass_cnt++;
    run_access(1'b1, 64'h80000000, 2'd3, 1'b0, 64'h1, 64'd0, -1);
    total_cnt++; if (obs_wr_cyc !== 8 || obs_fault !== 1'b1) $display("FAIL timeout_write got %0d/%b exp 8/1", obs_wr_cyc, obs_fault); else pass_cnt++;
`else
    run_access(1'b0, 64'h80000000, 2'd3, 1'b0, 64'd0, 64'd0, -1);
    total_cnt++; if (obs_got !== 1'b0 || mem_read !== 1'b1) $display("FAIL no_timeout_wait got resp=%b read=%b exp 0/1", obs_got, mem_read); else pass_cnt++;
    mem_ack = 1'b1; mem_rdata = 64'h0123;
    @(negedge clk);
    mem_ack = 1'b0;
    total_cnt++; if (resp_valid !== 1'b1 || resp_fault !== 1'b0 || resp_rdata !== 64'h0123) $display("FAIL late_ack_resp got %b/%b/%h exp 1/0/%h", resp_valid, resp_fault, resp_rdata, 64'h0123); else pass_cnt++;
    resp_ready = 1'b1;
    @(negedge clk);
    resp_ready = 1'b0;
`endif
  endtask

  initial begin
    test_reset;
    test_loads;
    test_stores;
    test_misaligned;
    test_backpressure;
    test_reset_mid_read;
    test_timeout;
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule
